// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port word RAM between instruction fetch and
// the load/store/AMO unit. Round-robin between the two ports. While dlock is
// held by the data port, the instruction port cannot win the RAM, which keeps
// AMO read-modify-write sequences atomic.
//
// Ports:
//   CLK, nRST                   clock, asynchronous active-low reset
//   iren, iaddr                 instruction read request (held until iready)
//   iload, iready               instruction read data, one-cycle completion pulse
//   dren, dwen, daddr, dstore,  data read/write request (held until dready),
//   dwidth, dlock               access width, data-port ownership lock
//   dload, dready               data read data, one-cycle completion pulse
//   ram_addr, ram_store,        registered command to the RAM wrapper
//   ram_wen, ram_width
//   ram_load                    RAM read data, valid READ_LAT cycles after the address
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  iren,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  output logic [31:0]           iload,
  output logic                  iready,
  input  logic                  dren,
  input  logic                  dwen,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [31:0]           dstore,
  input  logic [1:0]            dwidth,
  input  logic                  dlock,
  output logic [31:0]           dload,
  output logic                  dready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_store,
  output logic                  ram_wen,
  output logic [1:0]            ram_width,
  input  logic [31:0]           ram_load
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic {INSTR, DATA} port_t;

  state_t                state, state_n;
  port_t                 last_grant, last_grant_n;
  port_t                 owner, owner_n;
  logic                  is_wr, is_wr_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] ram_addr_n;
  logic [31:0]           ram_store_n;
  logic                  ram_wen_n;
  logic [1:0]            ram_width_n;
  logic [31:0]           iload_n, dload_n;
  logic                  iready_n, dready_n;

  logic req_i_c, req_d_c, grant_d_c;

  // State and registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      last_grant <= INSTR;
      owner      <= INSTR;
      is_wr      <= 1'b0;
      cnt        <= '0;
      ram_addr   <= '0;
      ram_store  <= '0;
      ram_wen    <= 1'b0;
      ram_width  <= '0;
      iload      <= '0;
      dload      <= '0;
      iready     <= 1'b0;
      dready     <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      owner      <= owner_n;
      is_wr      <= is_wr_n;
      cnt        <= cnt_n;
      ram_addr   <= ram_addr_n;
      ram_store  <= ram_store_n;
      ram_wen    <= ram_wen_n;
      ram_width  <= ram_width_n;
      iload      <= iload_n;
      dload      <= dload_n;
      iready     <= iready_n;
      dready     <= dready_n;
    end
  end

  // Arbitration, access sequencing and next-state logic
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    owner_n      = owner;
    is_wr_n      = is_wr;
    cnt_n        = cnt;
    ram_addr_n   = ram_addr;
    ram_store_n  = ram_store;
    ram_wen_n    = 1'b0;
    ram_width_n  = ram_width;
    iload_n      = iload;
    dload_n      = dload;
    iready_n     = 1'b0;
    dready_n     = 1'b0;

    // A locked data owner masks the instruction port even when the data port is idle
    req_i_c   = iren && !(dlock && (last_grant == DATA));
    req_d_c   = dren || dwen;
    grant_d_c = req_d_c && (!req_i_c || (last_grant == INSTR));

    unique case (state)
      IDLE: begin
        if (req_i_c || req_d_c) begin
          if (grant_d_c) begin
            owner_n      = DATA;
            last_grant_n = DATA;
            ram_addr_n   = daddr;
            ram_width_n  = dwidth;
            ram_store_n  = dstore;
            ram_wen_n    = dwen;
            is_wr_n      = dwen;
          end else begin
            owner_n      = INSTR;
            last_grant_n = INSTR;
            ram_addr_n   = iaddr;
            ram_width_n  = 2'b10;
            is_wr_n      = 1'b0;
          end
          state_n = ACCESS;
        end
      end

      ACCESS: begin
        if (is_wr) begin
          // Ready is registered, so it is raised on entry to RESP
          dready_n = (owner == DATA);
          iready_n = (owner == INSTR);
          state_n  = RESP;
        end else begin
          cnt_n   = CNT_W'(READ_LAT - 1);
          state_n = WAIT;
        end
      end

      WAIT: begin
        if (cnt == '0) begin
          if (owner == DATA) begin
            dload_n  = ram_load;
            dready_n = 1'b1;
          end else begin
            iload_n  = ram_load;
            iready_n = 1'b1;
          end
          state_n = RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one instance with READ_LAT=1 and one with READ_LAT=3,
// each backed by a behavioural byte-lane RAM. Expected completions are queued
// when requests are issued and matched against ready pulses.
module tb_ram_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iren   [2];
  logic [31:0] iaddr  [2];
  logic [31:0] iload  [2];
  logic        iready [2];
  logic        dren   [2];
  logic        dwen   [2];
  logic [31:0] daddr  [2];
  logic [31:0] dstore [2];
  logic [1:0]  dwidth [2];
  logic        dlock  [2];
  logic [31:0] dload  [2];
  logic        dready [2];
  logic [31:0] ram_addr  [2];
  logic [31:0] ram_store [2];
  logic        ram_wen   [2];
  logic [1:0]  ram_width [2];
  logic [31:0] ram_load  [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        port;   // 1 = data, 0 = instruction
    logic [31:0] data;   // expected load register value at the ready pulse
    int          cyc;    // expected ready cycle
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];

  ram_arbiter #(.ADDR_WIDTH(32), .READ_LAT(1)) u_dut1 (
    .CLK(CLK), .nRST(nRST),
    .iren(iren[0]), .iaddr(iaddr[0]), .iload(iload[0]), .iready(iready[0]),
    .dren(dren[0]), .dwen(dwen[0]), .daddr(daddr[0]), .dstore(dstore[0]),
    .dwidth(dwidth[0]), .dlock(dlock[0]), .dload(dload[0]), .dready(dready[0]),
    .ram_addr(ram_addr[0]), .ram_store(ram_store[0]), .ram_wen(ram_wen[0]),
    .ram_width(ram_width[0]), .ram_load(ram_load[0])
  );

  ram_arbiter #(.ADDR_WIDTH(32), .READ_LAT(3)) u_dut3 (
    .CLK(CLK), .nRST(nRST),
    .iren(iren[1]), .iaddr(iaddr[1]), .iload(iload[1]), .iready(iready[1]),
    .dren(dren[1]), .dwen(dwen[1]), .daddr(daddr[1]), .dstore(dstore[1]),
    .dwidth(dwidth[1]), .dlock(dlock[1]), .dload(dload[1]), .dready(dready[1]),
    .ram_addr(ram_addr[1]), .ram_store(ram_store[1]), .ram_wen(ram_wen[1]),
    .ram_width(ram_width[1]), .ram_load(ram_load[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural RAMs: byte lane from addr[1:0], store data right-aligned
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] pipe0;
  logic [31:0] pipe3 [3];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] w, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (w)
      2'b00:   r[int'(lane) * 8 +: 8]     = d[7:0];
      2'b01:   r[int'(lane[1]) * 16 +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge CLK) begin
    if (ram_wen[0])
      mem0[ram_addr[0][9:2]] <= merge(mem0[ram_addr[0][9:2]], ram_store[0], ram_width[0], ram_addr[0][1:0]);
    pipe0 <= mem0[ram_addr[0][9:2]];
  end
  assign ram_load[0] = pipe0;

  always @(posedge CLK) begin
    if (ram_wen[1])
      mem1[ram_addr[1][9:2]] <= merge(mem1[ram_addr[1][9:2]], ram_store[1], ram_width[1], ram_addr[1][1:0]);
    pipe3[0] <= mem1[ram_addr[1][9:2]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ram_load[1] = pipe3[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int s, input logic p, input logic [31:0] d, input int c);
    sb_t e;
    e.port = p;
    e.data = d;
    e.cyc  = c;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Scoreboard: every ready pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    sb_t e;
    bit  have;
    if (nRST) begin
      for (int k = 0; k < 2; k++) begin
        if (iready[k] || dready[k]) begin
          have = 1'b0;
          if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          chk("ready_expected", 32'(have), 32'd1);
          if (have) begin
            chk("ready_port", 32'(dready[k]), 32'(e.port));
            chk("ready_cycle", 32'(cyc), 32'(e.cyc));
            chk("load_data", e.port ? dload[k] : iload[k], e.data);
          end
        end
      end
    end
  end

  // Callers enter just after a rising edge; returns one cycle after iready
  task automatic ireq(input int s, input logic [31:0] a);
    bit got;
    iren[s]  = 1'b1;
    iaddr[s] = a;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (iready[s]) begin got = 1'b1; break; end
    end
    chk("iready_timeout", 32'(got), 32'd1);
    @(posedge CLK); #1;
    iren[s] = 1'b0;
  endtask

  task automatic dreq(input int s, input logic wr, input logic [31:0] a,
                      input logic [31:0] st, input logic [1:0] w);
    bit got;
    dren[s]   = !wr;
    dwen[s]   = wr;
    daddr[s]  = a;
    dstore[s] = st;
    dwidth[s] = w;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (dready[s]) begin got = 1'b1; break; end
    end
    chk("dready_timeout", 32'(got), 32'd1);
    @(posedge CLK); #1;
    dren[s] = 1'b0;
    dwen[s] = 1'b0;
  endtask

  task automatic reset_checks();
    for (int s = 0; s < 2; s++) begin
      chk("rst_ram_addr",  ram_addr[s], 32'h0);
      chk("rst_ram_store", ram_store[s], 32'h0);
      chk("rst_ram_wen",   32'(ram_wen[s]), 32'h0);
      chk("rst_ram_width", 32'(ram_width[s]), 32'h0);
      chk("rst_iready",    32'(iready[s]), 32'h0);
      chk("rst_dready",    32'(dready[s]), 32'h0);
      chk("rst_iload",     iload[s], 32'h0);
      chk("rst_dload",     dload[s], 32'h0);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    nRST = 1'b0;
    #2;
    reset_checks();
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    mem0[32'h10 >> 2]  = 32'h00A00093;
    mem0[32'h204 >> 2] = 32'h11223344;
    mem0[32'h280 >> 2] = 32'h99999999;
    mem1[32'h10 >> 2]  = 32'h00A00093;
    mem1[32'h40 >> 2]  = 32'hCAFEF00D;
    for (int s = 0; s < 2; s++) begin
      iren[s] = 1'b0; iaddr[s] = '0; dren[s] = 1'b0; dwen[s] = 1'b0;
      daddr[s] = '0; dstore[s] = '0; dwidth[s] = '0; dlock[s] = 1'b0;
    end
    nRST = 1'b0;
    #2;
    reset_checks();
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Instruction read: command visible in R+1, iready in R+3
    push(0, 1'b0, 32'h00A00093, cyc + 3);
    fork
      ireq(0, 32'h10);
      begin
        @(posedge CLK); #1;
        chk("t1_ram_addr",  ram_addr[0], 32'h10);
        chk("t1_ram_width", 32'(ram_width[0]), 32'h2);
        chk("t1_ram_wen",   32'(ram_wen[0]), 32'h0);
      end
    join

    // Byte write: ram_wen for exactly R+1, dready in R+2, then read back
    push(0, 1'b1, 32'h0, cyc + 2);
    fork
      dreq(0, 1'b1, 32'h204, 32'h000000AB, 2'b00);
      begin
        @(posedge CLK); #1;
        chk("t2_ram_wen",   32'(ram_wen[0]), 32'h1);
        chk("t2_ram_width", 32'(ram_width[0]), 32'h0);
        chk("t2_ram_addr",  ram_addr[0], 32'h204);
        chk("t2_ram_store", ram_store[0], 32'hAB);
        @(posedge CLK); #1;
        chk("t2_ram_wen_off", 32'(ram_wen[0]), 32'h0);
      end
    join
    push(0, 1'b1, 32'h112233AB, cyc + 3);
    dreq(0, 1'b0, 32'h204, 32'h0, 2'b10);

    // Contention from reset: data first, then instruction; data re-request loses to instruction
    do_reset();
    r = cyc;
    push(0, 1'b1, 32'h112233AB, r + 3);
    push(0, 1'b0, 32'h00A00093, r + 7);
    push(0, 1'b1, 32'h112233AB, r + 10);
    fork
      ireq(0, 32'h10);
      begin
        dreq(0, 1'b0, 32'h204, 32'h0, 2'b10);
        dreq(0, 1'b1, 32'h300, 32'hDEADBEEF, 2'b10);
      end
    join

    // Lock: instruction waits through three data accesses and two idle locked cycles
    r = cyc;
    push(0, 1'b1, 32'hDEADBEEF, r + 3);
    push(0, 1'b1, 32'hDEADBEEF, r + 6);
    push(0, 1'b1, 32'h5555BEEF, r + 10);
    push(0, 1'b0, 32'h00A00093, r + 16);
    fork
      ireq(0, 32'h10);
      begin
        dlock[0] = 1'b1;
        dreq(0, 1'b0, 32'h300, 32'h0, 2'b10);
        dreq(0, 1'b1, 32'h302, 32'h00005555, 2'b01);
        dreq(0, 1'b0, 32'h300, 32'h0, 2'b10);
        repeat (2) begin @(posedge CLK); #1; end
        dlock[0] = 1'b0;
      end
    join

    // Reset during a write's ACCESS cycle: ram_wen drops at once, write never lands
    dwen[0] = 1'b1; daddr[0] = 32'h280; dstore[0] = 32'h77; dwidth[0] = 2'b10;
    @(posedge CLK); #1;
    chk("t5_wen_pre", 32'(ram_wen[0]), 32'h1);
    #2;
    nRST = 1'b0;
    #1;
    chk("t5_wen_abort",    32'(ram_wen[0]), 32'h0);
    chk("t5_dready_abort", 32'(dready[0]), 32'h0);
    dwen[0] = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    push(0, 1'b0, 32'h00A00093, cyc + 3);
    ireq(0, 32'h10);
    push(0, 1'b1, 32'h99999999, cyc + 3);
    dreq(0, 1'b0, 32'h280, 32'h0, 2'b10);

    // READ_LAT=3: read in R+5, write leaves dload unchanged
    push(1, 1'b1, 32'hCAFEF00D, cyc + 5);
    dreq(1, 1'b0, 32'h40, 32'h0, 2'b10);
    push(1, 1'b1, 32'hCAFEF00D, cyc + 2);
    dreq(1, 1'b1, 32'h40, 32'h01020304, 2'b10);
    push(1, 1'b1, 32'h01020304, cyc + 5);
    dreq(1, 1'b0, 32'h40, 32'h0, 2'b10);

    // Reset during WAIT: no ready pulse, load cleared, fresh fetch completes
    dren[1] = 1'b1; daddr[1] = 32'h40; dwidth[1] = 2'b10;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #2;
    nRST = 1'b0;
    #1;
    chk("t7_dready_abort", 32'(dready[1]), 32'h0);
    chk("t7_wen_abort",    32'(ram_wen[1]), 32'h0);
    chk("t7_dload_rst",    dload[1], 32'h0);
    chk("t7_addr_rst",     ram_addr[1], 32'h0);
    dren[1] = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    repeat (6) begin @(posedge CLK); #1; end
    push(1, 1'b0, 32'h00A00093, cyc + 5);
    ireq(1, 32'h10);

    repeat (3) begin @(posedge CLK); #1; end
    chk("sb0_drained", 32'(q0.size()), 32'h0);
    chk("sb1_drained", 32'(q1.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
